// File: rtl/burst_mem_pkg.sv
// burst_mem_pkg: shared widths and FSM state types for the burst memory responder
package burst_mem_pkg;
  localparam int BEATS_PER_LINE = 4;
  localparam int BEAT_WIDTH = 64;
  localparam int LINE_WIDTH = BEATS_PER_LINE * BEAT_WIDTH;
  typedef enum logic [1:0] {W_IDLE, W_BEAT1, W_BEAT2, W_BEAT3} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
endpackage

// File: rtl/burst_mem_req_fifo.sv
// burst_mem_req_fifo: small FIFO of outstanding read addresses; full/empty reflect the pre-update count
module burst_mem_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rp];
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  // pointers and occupancy; a refused push on full never disturbs the count
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  // address storage, not reset
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= din;
endmodule

// File: rtl/burst_mem_responder.sv
// burst_mem_responder: 4-beat line memory with queued in-order read bursts; BURST_MEM_RANDOM_STALL_EN adds LFSR ready stalls
module burst_mem_responder import burst_mem_pkg::*; #(
  parameter int DEPTH_LINES = 256,
  parameter int READ_LATENCY = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           dfp_addr,
  input  logic                  dfp_read,
  input  logic                  dfp_write,
  input  logic [BEAT_WIDTH-1:0] dfp_wdata,
  output logic                  dfp_ready,
  output logic [31:0]           dfp_raddr,
  output logic [BEAT_WIDTH-1:0] dfp_rdata,
  output logic                  dfp_rvalid
);
  localparam int IW = $clog2(DEPTH_LINES);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LATENCY - 1);

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  logic [IW-1:0] w_line, w_line_n, wr_line;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] beat, beat_n, wr_beat;
  logic wr_en, push, pop, full, empty, stall;
  logic [31:0] head;
  logic [QW:0] count;
  logic [BEAT_WIDTH-1:0] mem [DEPTH_LINES*BEATS_PER_LINE];
  logic [BEAT_WIDTH-1:0] rdata_q;
  logic [31:0] raddr_q;

`ifdef BURST_MEM_RANDOM_STALL_EN
  logic [15:0] lfsr;
  // free-running Fibonacci LFSR; low two bits zero stalls the request port
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif

  burst_mem_req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(dfp_addr),
    .full(full), .empty(empty), .head(head), .count(count)
  );

  // write FSM next state, ready, beat store and read-queue push; a write always beats a read in W_IDLE
  always_comb begin
    w_next = w_state;
    w_line_n = w_line;
    wr_en = 1'b0;
    wr_beat = w_state;
    wr_line = w_line;
    push = 1'b0;
    dfp_ready = rst && !stall && (w_state == W_IDLE ? !full : 1'b1);
    if (w_state == W_IDLE) begin
      wr_line = dfp_addr[5 +: IW];
      if (dfp_write && dfp_ready) begin
        wr_en = 1'b1;
        w_line_n = wr_line;
        w_next = W_BEAT1;
      end else push = dfp_read && !dfp_write && dfp_ready;
    end else if (dfp_ready) begin
      wr_en = 1'b1;
      w_next = w_state_e'(w_state + 2'd1);
    end
  end

  // write FSM state and latched line index
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_state <= W_IDLE;
      w_line <= '0;
    end else begin
      w_state <= w_next;
      w_line <= w_line_n;
    end

  // read FSM: latency countdown lands on zero as the burst starts; back-to-back requests skip R_IDLE
  always_comb begin
    r_next = r_state;
    cnt_n = cnt;
    beat_n = beat;
    pop = 1'b0;
    case (r_state)
      R_IDLE: if (!empty) begin
        r_next = R_WAIT;
        cnt_n = LAT_LOAD;
      end
      R_WAIT: begin
        cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
        beat_n = '0;
        if (cnt <= CW'(1)) r_next = R_BURST;
      end
      R_BURST: begin
        beat_n = beat + 1'b1;
        if (beat == 2'd3) begin
          pop = 1'b1;
          cnt_n = LAT_LOAD;
          r_next = (push || count > (QW+1)'(1)) ? R_WAIT : R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // read FSM state, latency counter, beat index and held output values
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= R_IDLE;
      cnt <= '0;
      beat <= '0;
      rdata_q <= '0;
      raddr_q <= '0;
    end else begin
      r_state <= r_next;
      cnt <= cnt_n;
      beat <= beat_n;
      rdata_q <= dfp_rdata;
      raddr_q <= dfp_raddr;
    end

  // beat-granular storage, never cleared so reset keeps completed writes
  always_ff @(posedge clk)
    if (wr_en) mem[{wr_line, wr_beat}] <= dfp_wdata;

  assign dfp_rvalid = r_state == R_BURST;
  assign dfp_rdata = dfp_rvalid ? mem[{head[5 +: IW], beat}] : rdata_q;
  assign dfp_raddr = dfp_rvalid ? (head & 32'hFFFF_FFE0) : raddr_q;
endmodule
